spi_slave_duplex: RTL and testbench

Full-duplex SPI slave for the user_clk domain: deserialises mosi into words and serialises user-supplied words onto miso in the same frame. It is the responder end of the spi_master link, completing the miso path that the receive-only slave leaves unconnected. sclk, mcs and mosi are oversampled by user_clk; no logic is clocked by sclk.

---
 rtl/spi_slave_duplex.sv | 194 +++++++++++++++++++
 tb/tb_spi_slave_duplex.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_duplex.sv
// Full-duplex SPI slave; sclk/mcs/mosi oversampled by user_clk.
// Define SPI_SLAVE_DUPLEX_TIMEOUT_EN to enable the frame timeout and o_err.
module spi_slave_duplex #(
    parameter logic [31:0] USER_CLK_RATE = 32'd100_000_000,
    parameter logic [31:0] SPI_CLK_RATE = 32'd2_500_000,
    parameter logic MCS_VALID_LEVEL = 1'b0,
    parameter logic [1:0] SCK_MODE = 2'b10,
    parameter logic DATA_ENDIAN = 1'b1,
    parameter int DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] DUMMY_WORD = '1
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic                  i_tx_evt,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    output logic                  o_tx_ready,
    output logic                  o_tx_underrun,
    output logic                  o_rx_evt,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_err,
    input  logic                  mcs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic CPOL = SCK_MODE[1];
    localparam logic CPHA = SCK_MODE[0];
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    if (SPI_CLK_RATE > USER_CLK_RATE / 32'd8) begin : g_rate_chk
        $error("SPI_CLK_RATE must not exceed USER_CLK_RATE/8");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t state_q, state_d;
    logic [2:0] sclk_s_q, sclk_s_d, mcs_s_q, mcs_s_d;
    logic [1:0] mosi_s_q, mosi_s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d, tx_q, tx_d, hold_q, hold_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic hold_full_q, hold_full_d, tx_ready_q, tx_ready_d;
    logic rx_evt_q, rx_evt_d, ur_q, ur_d, miso_q, miso_d;

    logic rise, fall, lead_e, trail_e, sample_e, shift_e;
    logic mcs_act, mcs_on;
    logic [DATA_WIDTH-1:0] rx_shift, load_word, load_shift, tx_next;
    logic load_bit, tx_bit;

    assign rise = sclk_s_q[1] & ~sclk_s_q[2];
    assign fall = ~sclk_s_q[1] & sclk_s_q[2];
    assign lead_e = CPOL ? fall : rise;
    assign trail_e = CPOL ? rise : fall;
    assign sample_e = CPHA ? trail_e : lead_e;
    assign shift_e = CPHA ? lead_e : trail_e;
    assign mcs_act = (mcs_s_q[1] == MCS_VALID_LEVEL);
    assign mcs_on = mcs_act & (mcs_s_q[2] != MCS_VALID_LEVEL);

    assign rx_shift = DATA_ENDIAN ? {rx_q[DATA_WIDTH-2:0], mosi_s_q[1]}
                                  : {mosi_s_q[1], rx_q[DATA_WIDTH-1:1]};
    assign load_word = hold_full_q ? hold_q : DUMMY_WORD;
    assign load_bit = DATA_ENDIAN ? load_word[DATA_WIDTH-1] : load_word[0];
    assign load_shift = DATA_ENDIAN ? (load_word << 1) : (load_word >> 1);
    assign tx_bit = DATA_ENDIAN ? tx_q[DATA_WIDTH-1] : tx_q[0];
    assign tx_next = DATA_ENDIAN ? (tx_q << 1) : (tx_q >> 1);

`ifdef SPI_SLAVE_DUPLEX_TIMEOUT_EN
    localparam logic [31:0] TO_CYC = 32'd4 * (USER_CLK_RATE / SPI_CLK_RATE);
    logic [31:0] to_q, to_d;
    logic err_q, err_d, any_e;
    assign any_e = sclk_s_q[1] ^ sclk_s_q[2];
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sclk_s_d = {sclk_s_q[1:0], sclk};
        mcs_s_d = {mcs_s_q[1:0], mcs};
        mosi_s_d = {mosi_s_q[0], mosi};
        cnt_d = cnt_q;
        rx_d = rx_q;
        tx_d = tx_q;
        hold_d = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d = rx_data_q;
        rx_evt_d = 1'b0;
        ur_d = 1'b0;
        miso_d = miso_q;
`ifdef SPI_SLAVE_DUPLEX_TIMEOUT_EN
        to_d = 32'd0;
        err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mcs_on) state_d = LOAD;
            end
            LOAD: begin
                hold_full_d = 1'b0;
                ur_d = ~hold_full_q;
                tx_d = CPHA ? load_word : load_shift;
                if (!CPHA) miso_d = load_bit;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (sample_e) begin
                    rx_d = rx_shift;
                    if (cnt_q == LAST) begin
                        rx_data_d = rx_shift;
                        rx_evt_d = 1'b1;
                        cnt_d = '0;
                        state_d = mcs_act ? LOAD : IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (!mcs_act) begin
                    cnt_d = '0;
                    state_d = IDLE;
                end else if (shift_e && (CPHA || cnt_q != '0)) begin
                    // CPHA=0 already drove bit 0 in LOAD
                    miso_d = tx_bit;
                    tx_d = tx_next;
                end
`ifdef SPI_SLAVE_DUPLEX_TIMEOUT_EN
                to_d = any_e ? 32'd0 : to_q + 32'd1;
                if (mcs_act && !any_e && to_q == TO_CYC - 32'd1) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                    to_d = 32'd0;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        // a write landing with LOAD is kept; LOAD used the old word
        if (i_tx_evt && (!hold_full_q || state_q == LOAD)) begin
            hold_d = i_tx_data;
            hold_full_d = 1'b1;
        end
        tx_ready_d = ~hold_full_d;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q <= IDLE;
            sclk_s_q <= {3{CPOL}};
            mcs_s_q <= {3{~MCS_VALID_LEVEL}};
            mosi_s_q <= '0;
            cnt_q <= '0;
            rx_q <= '0;
            tx_q <= '0;
            hold_q <= '0;
            hold_full_q <= 1'b0;
            tx_ready_q <= 1'b1;
            rx_data_q <= '0;
            rx_evt_q <= 1'b0;
            ur_q <= 1'b0;
            miso_q <= 1'b0;
`ifdef SPI_SLAVE_DUPLEX_TIMEOUT_EN
            to_q <= 32'd0;
            err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sclk_s_q <= sclk_s_d;
            mcs_s_q <= mcs_s_d;
            mosi_s_q <= mosi_s_d;
            cnt_q <= cnt_d;
            rx_q <= rx_d;
            tx_q <= tx_d;
            hold_q <= hold_d;
            hold_full_q <= hold_full_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q <= rx_data_d;
            rx_evt_q <= rx_evt_d;
            ur_q <= ur_d;
            miso_q <= miso_d;
`ifdef SPI_SLAVE_DUPLEX_TIMEOUT_EN
            to_q <= to_d;
            err_q <= err_d;
`endif
        end
    end

    assign o_tx_ready = tx_ready_q;
    assign o_tx_underrun = ur_q;
    assign o_rx_evt = rx_evt_q;
    assign o_rx_data = rx_data_q;
    assign miso = miso_q;
endmodule

// File: tb/tb_spi_slave_duplex.sv
// Scoreboard bench for spi_slave_duplex: four SPI modes, LSB-first,
// underrun, back-to-back words, aborted frame, async reset, optional timeout.
`timescale 1ns/1ps
module tb_spi_slave_duplex;
    localparam int N = 5;
    localparam int H = 200;
    localparam logic [1:0] MODES [N] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    localparam logic ENDS [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] mcs_v, sclk_v, tx_evt_v;
    logic [N-1:0] ready_v, ur_v, rxe_v, err_v, miso_v;
    logic mosi;
    logic [15:0] tx_data;
    logic [15:0] rxd_a [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_slave_duplex #(
            .SCK_MODE(MODES[g]),
            .DATA_ENDIAN(ENDS[g])
        ) u_dut (
            .user_clk(clk),
            .user_rst_n(rst_n),
            .i_tx_evt(tx_evt_v[g]),
            .i_tx_data(tx_data),
            .o_tx_ready(ready_v[g]),
            .o_tx_underrun(ur_v[g]),
            .o_rx_evt(rxe_v[g]),
            .o_rx_data(rxd_a[g]),
            .o_err(err_v[g]),
            .mcs(mcs_v[g]),
            .sclk(sclk_v[g]),
            .mosi(mosi),
            .miso(miso_v[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int evt_cnt = 0;
    int ur_cnt = 0;
    int err_cnt = 0;
    int ur_snap = 0;
    logic [15:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (rxe_v[g] === 1'b1) begin
                evt_cnt++;
                ur_snap = ur_cnt;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_evt_unexpected: inst %0d data %h, none expected",
                             g, rxd_a[g]);
                end else begin
                    chk("rx_data", {16'h0, rxd_a[g]}, {16'h0, exp_q.pop_front()});
                end
            end
            if (ur_v[g] === 1'b1) ur_cnt++;
            if (err_v[g] === 1'b1) err_cnt++;
        end
    end

    task automatic preload(input int g, input logic [15:0] w);
        @(negedge clk);
        tx_data = w;
        tx_evt_v[g] = 1'b1;
        @(negedge clk);
        tx_evt_v[g] = 1'b0;
        chk("tx_ready_clear", {31'h0, ready_v[g]}, 32'h0);
    endtask

    task automatic master_xfer(input int g, input logic [31:0] mw,
                               input int nbits, input bit keep,
                               output logic [31:0] rd, output logic fb);
        logic cpol, cpha;
        int nw, k, j, b, idx;
        cpol = MODES[g][1];
        cpha = MODES[g][0];
        nw = (nbits + 15) / 16;
        rd = '0;
        fb = 1'b0;
        @(negedge clk);
        mcs_v[g] = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            k = i / 16;
            j = i % 16;
            b = ENDS[g] ? 15 - j : j;
            idx = 16 * (nw - 1 - k) + b;
            if (!cpha) begin
                mosi = mw[idx];
                #H;
                sclk_v[g] = ~cpol;
                rd[idx] = miso_v[g];
                #H;
                sclk_v[g] = cpol;
            end else begin
                #H;
                sclk_v[g] = ~cpol;
                mosi = mw[idx];
                #H;
                sclk_v[g] = cpol;
                rd[idx] = miso_v[g];
            end
            if (i == 0) fb = rd[idx];
        end
        if (!keep) begin
            #H;
            mcs_v[g] = 1'b1;
            #H;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic fb;
        int e0, u0, r0, n;
        mcs_v = '1;
        tx_evt_v = '0;
        mosi = 1'b0;
        tx_data = '0;
        for (int g = 0; g < N; g++) sclk_v[g] = MODES[g][1];
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", {27'h0, ready_v}, 32'h1f);
        chk("rst_underrun", {27'h0, ur_v}, 32'h0);
        chk("rst_rx_evt", {27'h0, rxe_v}, 32'h0);
        chk("rst_err", {27'h0, err_v}, 32'h0);
        chk("rst_miso", {27'h0, miso_v}, 32'h0);
        for (int g = 0; g < N; g++) chk("rst_rx_data", {16'h0, rxd_a[g]}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int g = 0; g < 4; g++) begin
            preload(g, 16'h3C96);
            exp_q.push_back(16'hA55A);
            e0 = evt_cnt;
            master_xfer(g, 32'h0000_A55A, 16, 1'b0, rd, fb);
            chk($sformatf("mode%0d_miso", g), rd, 32'h0000_3C96);
            chk($sformatf("mode%0d_evts", g), evt_cnt - e0, 1);
        end

        preload(4, 16'h8000);
        exp_q.push_back(16'h0001);
        e0 = evt_cnt;
        master_xfer(4, 32'h0000_0001, 16, 1'b0, rd, fb);
        chk("lsb_miso", rd, 32'h0000_8000);
        chk("lsb_first_bit", {31'h0, fb}, 32'h0);
        chk("lsb_evts", evt_cnt - e0, 1);

        u0 = ur_cnt;
        exp_q.push_back(16'h5AC3);
        e0 = evt_cnt;
        master_xfer(2, 32'h0000_5AC3, 16, 1'b0, rd, fb);
        chk("underrun_miso", rd, 32'h0000_FFFF);
        chk("underrun_pulses", ur_snap - u0, 1);
        chk("underrun_evts", evt_cnt - e0, 1);

        preload(2, 16'hC3A5);
        exp_q.push_back(16'h0F0F);
        exp_q.push_back(16'hF0F0);
        e0 = evt_cnt;
        u0 = ur_cnt;
        fork
            begin
                n = 0;
                while (ready_v[2] !== 1'b1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                chk("b2b_ready_seen", {31'h0, n < 400}, 32'h1);
                tx_data = 16'h1234;
                tx_evt_v[2] = 1'b1;
                @(negedge clk);
                tx_evt_v[2] = 1'b0;
            end
            master_xfer(2, 32'h0F0F_F0F0, 32, 1'b0, rd, fb);
        join
        chk("b2b_miso", rd, 32'hC3A5_1234);
        chk("b2b_evts", evt_cnt - e0, 2);
        chk("b2b_no_underrun", ur_snap - u0, 0);

        preload(2, 16'h1111);
        e0 = evt_cnt;
        master_xfer(2, 32'h0000_7F00, 7, 1'b0, rd, fb);
        chk("abort_evts", evt_cnt - e0, 0);
        preload(2, 16'h5AA5);
        exp_q.push_back(16'hBEEF);
        master_xfer(2, 32'h0000_BEEF, 16, 1'b0, rd, fb);
        chk("after_abort_miso", rd, 32'h0000_5AA5);
        chk("after_abort_evts", evt_cnt - e0, 1);

`ifdef SPI_SLAVE_DUPLEX_TIMEOUT_EN
        e0 = evt_cnt;
        r0 = err_cnt;
        n = -1;
        master_xfer(2, 32'h0000_F800, 5, 1'b1, rd, fb);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (err_v[2] === 1'b1 && n < 0) n = c;
        end
        mcs_v[2] = 1'b1;
        repeat (40) @(negedge clk);
        chk("timeout_err_pulses", err_cnt - r0, 1);
        chk("timeout_err_cycle", {31'h0, (n >= 150 && n <= 175)}, 32'h1);
        chk("timeout_evts", evt_cnt - e0, 0);
`else
        r0 = err_cnt;
        chk("no_err_pulses", err_cnt - r0 + {31'h0, err_v[2]}, 0);
`endif

        e0 = evt_cnt;
        master_xfer(2, 32'h0000_0000, 5, 1'b1, rd, fb);
        preload(2, 16'h4242);
        chk("pre_rst_miso", {31'h0, miso_v[2]}, 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'h0, ready_v[2]}, 32'h1);
        chk("mid_rst_underrun", {31'h0, ur_v[2]}, 32'h0);
        chk("mid_rst_rx_evt", {31'h0, rxe_v[2]}, 32'h0);
        chk("mid_rst_rx_data", {16'h0, rxd_a[2]}, 32'h0);
        chk("mid_rst_miso", {31'h0, miso_v[2]}, 32'h0);
        chk("mid_rst_err", {31'h0, err_v[2]}, 32'h0);
        mcs_v[2] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_rst_evts", evt_cnt - e0, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
